// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the uart_tx message arbiter.
package uart_arb_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int HOLDOFF_DEF      = 3;
  localparam int LOCK_TIMEOUT_DEF = 4800000;  // ~100 ms at 48 MHz

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set bit of req at or
// after ptr, wrapping. Stateless so other arbiters can reuse it.
module rr_pick #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  int j;

  // Walk from farthest to nearest so the nearest hit is the last assignment.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        found = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ requesters, locking per message so
// lines never interleave; paces on tx_ready with a post-strobe holdoff.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int HOLDOFF      = HOLDOFF_DEF,
  parameter  int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                 clk_48,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_strobe,
  input  logic                 tx_ready,
  output logic                 grant_valid,
  output logic [IDW-1:0]       grant_id
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT);

  arb_state_t                 state;
  logic [IDW-1:0]             rr_ptr;
  logic [IDW-1:0]             pick_idx;
  logic                       pick_found;
  logic [IDW-1:0]             nxt_ptr;
  logic [HW-1:0]              holdoff_cnt;
  logic [TW-1:0]              idle_cnt;
  logic                       xfer;
  logic                       timeout;
  logic [NUM_REQ-1:0][7:0]    req_bytes;

  assign req_bytes = req_data;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign grant_valid = (state == LOCKED);

  // Only the locked requester can ever see ready; holdoff masks the stale
  // tx_ready high that uart_tx still shows right after a strobe.
  always_comb begin
    req_ready = '0;
    if (!reset && state == LOCKED && tx_ready && holdoff_cnt == '0)
      req_ready[grant_id] = req_valid[grant_id];
  end

  assign xfer    = |req_ready;
  assign timeout = (state == LOCKED) && !xfer && (idle_cnt == TW'(LOCK_TIMEOUT - 1));
  assign nxt_ptr = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      holdoff_cnt <= '0;
      idle_cnt    <= '0;
      tx_strobe   <= 1'b0;
      tx_data     <= '0;
    end else begin
      tx_strobe <= xfer;
      if (xfer) begin
        tx_data     <= req_bytes[grant_id];
        holdoff_cnt <= HW'(HOLDOFF);
      end else if (holdoff_cnt != '0) begin
        holdoff_cnt <= holdoff_cnt - 1'b1;
      end

      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= LOCKED;
          end
        end
        LOCKED: begin
          // A transfer outranks a timeout landing in the same cycle.
          if (xfer) begin
            idle_cnt <= '0;
            if (req_last[grant_id]) begin
              state  <= IDLE;
              rr_ptr <= nxt_ptr;
            end
          end else if (timeout) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end else if (idle_cnt != '1) begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-requester byte queues, a simple
// uart_tx ready model and a strobe log checked against hand-computed values.
module tb_uart_tx_arbiter;

  localparam int NR        = 4;
  localparam int HO        = 3;
  localparam int LT        = 20;
  localparam int UART_BYTE = 160;  // 10 bits at 16 clocks/bit

  logic            clk_48 = 1'b0;
  logic            reset  = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_strobe;
  logic            tx_ready;
  logic            grant_valid;
  logic [1:0]      grant_id;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int busy  = 0;
  bit uart_mode = 1'b0;

  logic [8:0]    q [NR][$];
  logic [NR-1:0] acc;
  logic [7:0]    s_data [$];
  logic [1:0]    s_id   [$];
  int            s_cyc  [$];

  uart_tx_arbiter #(.NUM_REQ(NR), .HOLDOFF(HO), .LOCK_TIMEOUT(LT)) dut (
    .clk_48      (clk_48),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_strobe   (tx_strobe),
    .tx_ready    (tx_ready),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk_48 = ~clk_48;
  always @(posedge clk_48) cyc <= cyc + 1;

  assign tx_ready = uart_mode ? (busy == 0) : 1'b1;

  // uart_tx stand-in: busy for one byte time from the strobe cycle on.
  initial begin
    forever begin
      @(posedge clk_48); #2;
      if (tx_strobe) busy = UART_BYTE;
      else if (busy > 0) busy--;
    end
  end

  always @(negedge clk_48) begin
    if (tx_strobe === 1'b1) begin
      s_data.push_back(tx_data);
      s_id.push_back(grant_id);
      s_cyc.push_back(cyc);
    end
  end

  // Requester drivers: hold the head byte until accepted, then advance.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge clk_48);
      acc = req_valid & req_ready;
      @(posedge clk_48); #1;
      for (int i = 0; i < NR; i++) begin
        if (acc[i] && q[i].size() > 0) void'(q[i].pop_front());
        if (q[i].size() > 0) begin
          req_valid[i]       = 1'b1;
          req_data[8*i +: 8] = q[i][0][7:0];
          req_last[i]        = q[i][0][8];
        end else begin
          req_valid[i] = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int r, input bit last, input logic [7:0] d);
    q[r].push_back({last, d});
  endtask

  task automatic clear_log();
    s_data.delete();
    s_id.delete();
    s_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_48);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) q[i].delete();
    repeat (3) @(negedge clk_48);
    clear_log();
    reset = 1'b0;
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while (s_data.size() < n && k < budget) begin
      @(negedge clk_48); #1;
      k++;
    end
    chk(tag, s_data.size(), n);
  endtask

  initial begin
    int s, c0, k;
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, c0, k;
    // Reset state
    repeat (3) @(negedge clk_48);
    chk("rst_strobe", tx_strobe, 0);
    chk("rst_data", tx_data, 8'h00);
    chk("rst_ready", req_ready, 0);
    chk("rst_gv", grant_valid, 0);
    chk("rst_gid", grant_id, 0);
    @(negedge clk_48);
    reset = 1'b0;

    // Single requester paced by the uart model
    uart_mode = 1'b1;
    @(negedge clk_48);
    push(0, 1'b0, 8'h41); push(0, 1'b0, 8'h42); push(0, 1'b1, 8'h0A);
    wait_log("t1_cnt", 3, 1000);
    chk("t1_d0", s_data[0], 8'h41);
    chk("t1_d1", s_data[1], 8'h42);
    chk("t1_d2", s_data[2], 8'h0A);
    chk("t1_id", s_id[2], 0);
    chk("t1_gap", (s_cyc[1] - s_cyc[0]) >= UART_BYTE, 1);
    repeat (3) @(negedge clk_48);
    chk("t1_gv_end", grant_valid, 0);
    uart_mode = 1'b0;

    // Contention between 1 and 2 from rr_ptr=0: whole messages, no interleave
    do_reset();
    @(negedge clk_48);
    push(1, 1'b0, 8'h11); push(1, 1'b1, 8'h12);
    push(2, 1'b0, 8'h21); push(2, 1'b1, 8'h22);
    wait_log("t2_cnt", 4, 200);
    chk("t2_d0", s_data[0], 8'h11);
    chk("t2_d1", s_data[1], 8'h12);
    chk("t2_d2", s_data[2], 8'h21);
    chk("t2_d3", s_data[3], 8'h22);
    chk("t2_id1", s_id[1], 1);
    chk("t2_id2", s_id[2], 2);
    // rr_ptr should now be 3, so 3 wins over 0
    clear_log();
    push(0, 1'b1, 8'h01); push(3, 1'b1, 8'h03);
    wait_log("t2_ptr_cnt", 2, 200);
    chk("t2_ptr_first", s_id[0], 3);
    chk("t2_ptr_second", s_id[1], 0);

    // Fairness: all four streaming single-byte messages
    do_reset();
    @(negedge clk_48);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push(i, 1'b1, 8'(8'h30 + 16*r + i));
    wait_log("t3_cnt", 8, 400);
    for (int m = 0; m < 8; m++) begin
      chk($sformatf("t3_id%0d", m), s_id[m], m % NR);
      chk($sformatf("t3_d%0d", m), s_data[m], 8'(8'h30 + 16*(m/NR) + (m % NR)));
    end

    // Holdoff with tx_ready stuck high, plus first-byte latency
    do_reset();
    @(negedge clk_48);
    c0 = cyc;
    for (int i = 0; i < 5; i++) push(0, i == 4, 8'(8'h50 + i));
    wait_log("t4_cnt", 5, 200);
    chk("t4_lat", s_cyc[0] - c0, 3);
    for (int i = 1; i < 5; i++) chk($sformatf("t4_gap%0d", i), s_cyc[i] - s_cyc[i-1], HO + 1);
    repeat (6) @(negedge clk_48);
    chk("t4_no_extra", s_data.size(), 5);

    // Lock timeout: 3 stalls mid-message while 0 waits
    do_reset();
    @(negedge clk_48);
    push(3, 1'b0, 8'h55);
    wait_log("t5_cnt1", 1, 100);
    s = s_cyc[0];
    push(0, 1'b1, 8'h66);
    repeat (2) @(negedge clk_48);
    chk("t5_blocked", req_ready, 0);
    chk("t5_gid3", grant_id, 3);
    k = 0;
    while (grant_valid === 1'b1 && k < 200) begin
      @(negedge clk_48);
      k++;
    end
    chk("t5_revoke_at", cyc - s, LT);
    @(negedge clk_48);
    chk("t5_gv0", grant_valid, 1);
    chk("t5_gid0", grant_id, 0);
    wait_log("t5_cnt2", 2, 100);
    chk("t5_d", s_data[1], 8'h66);

    // Reset the cycle after a strobe, mid-message
    do_reset();
    @(negedge clk_48);
    push(1, 1'b0, 8'h77); push(1, 1'b0, 8'h78); push(1, 1'b1, 8'h79);
    wait_log("t6_cnt", 1, 100);
    @(negedge clk_48);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) q[i].delete();
    @(negedge clk_48);
    chk("t6_strobe", tx_strobe, 0);
    chk("t6_gv", grant_valid, 0);
    chk("t6_ready", req_ready, 0);
    reset = 1'b0;
    clear_log();
    push(0, 1'b1, 8'h5A);
    wait_log("t6_cnt2", 1, 100);
    chk("t6_id", s_id[0], 0);
    chk("t6_d", s_data[0], 8'h5A);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
